// File: rtl/board_label_gen.sv
// Two-stage chessboard coordinate label generator: decodes file/rank label cells and
// drives the font ROM address. Defining LABEL_HIGHLIGHT_EN adds the hl_file/hl_rank/label_hl highlight path.
module board_label_gen #(
    parameter int BOARD_X   = 256,
    parameter int BOARD_Y   = 128,
    parameter int SQ_LOG2   = 6,
    parameter int N_SQ      = 8,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 16,
    parameter int LABEL_GAP = 8,
    localparam int GW_LOG   = $clog2(GLYPH_W),
    localparam int GH_LOG   = $clog2(GLYPH_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              flip_req,
`ifdef LABEL_HIGHLIGHT_EN
    input  logic [3:0]        hl_file,
    input  logic [3:0]        hl_rank,
`endif
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic [6+GH_LOG:0] char_addr,
    output logic [GW_LOG-1:0] char_col,
    output logic              label_on
`ifdef LABEL_HIGHLIGHT_EN
    ,
    output logic              label_hl
`endif
);

    localparam int S     = 1 << SQ_LOG2;
    localparam int B     = N_SQ << SQ_LOG2;
    localparam int PAD_X = (S - GLYPH_W) / 2;
    localparam int PAD_Y = (S - GLYPH_H) / 2;
    localparam int FT_Y  = BOARD_Y - LABEL_GAP - GLYPH_H;
    localparam int FB_Y  = BOARD_Y + B + LABEL_GAP;
    localparam int RL_X  = BOARD_X - LABEL_GAP - GLYPH_W;
    localparam int RR_X  = BOARD_X + B + LABEL_GAP;

    int                xi, yi, dx, dy, off_x, off_y;
    logic              in_cols, in_rows, band_top, band_bot, col_left, col_right;
    logic              file_n, rank_n;
    logic [3:0]        idx_n;
    logic [GW_LOG-1:0] col_n;
    logic [GH_LOG-1:0] line_n;

    logic              file_q, rank_q, flip_active;
    logic [3:0]        idx_q;
    logic [GW_LOG-1:0] col_q;
    logic [GH_LOG-1:0] line_q;
    logic [10:0]       h1, v1;

    // Signed int arithmetic so pixels left of / above a bound compare as outside instead of wrapping.
    always_comb begin
        xi        = {21'd0, hcount_in};
        yi        = {21'd0, vcount_in};
        dx        = xi - BOARD_X;
        dy        = yi - BOARD_Y;
        off_x     = dx & (S - 1);
        off_y     = dy & (S - 1);
        in_cols   = (dx >= 0) && (dx < B) && (off_x >= PAD_X) && (off_x < PAD_X + GLYPH_W);
        in_rows   = (dy >= 0) && (dy < B) && (off_y >= PAD_Y) && (off_y < PAD_Y + GLYPH_H);
        band_top  = (yi >= FT_Y) && (yi < FT_Y + GLYPH_H);
        band_bot  = (yi >= FB_Y) && (yi < FB_Y + GLYPH_H);
        col_left  = (xi >= RL_X) && (xi < RL_X + GLYPH_W);
        col_right = (xi >= RR_X) && (xi < RR_X + GLYPH_W);
        file_n    = in_cols && (band_top || band_bot);
        rank_n    = in_rows && (col_left || col_right);
        idx_n     = '0;
        col_n     = '0;
        line_n    = '0;
        if (file_n) begin
            idx_n  = 4'(dx >>> SQ_LOG2);
            col_n  = GW_LOG'(off_x - PAD_X);
            line_n = GH_LOG'(yi - (band_top ? FT_Y : FB_Y));
        end else if (rank_n) begin
            idx_n  = 4'(dy >>> SQ_LOG2);
            col_n  = GW_LOG'(xi - (col_left ? RL_X : RR_X));
            line_n = GH_LOG'(off_y - PAD_Y);
        end
    end

    logic frame_start;
    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

`ifdef LABEL_HIGHLIGHT_EN
    logic [3:0] hl_file_q, hl_rank_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            file_q      <= 1'b0;
            rank_q      <= 1'b0;
            idx_q       <= '0;
            col_q       <= '0;
            line_q      <= '0;
            h1          <= '0;
            v1          <= '0;
            flip_active <= 1'b0;
`ifdef LABEL_HIGHLIGHT_EN
            hl_file_q   <= '0;
            hl_rank_q   <= '0;
`endif
        end else begin
            file_q <= file_n;
            rank_q <= rank_n;
            idx_q  <= idx_n;
            col_q  <= col_n;
            line_q <= line_n;
            h1     <= hcount_in;
            v1     <= vcount_in;
            if (frame_start) begin
                flip_active <= flip_req;
`ifdef LABEL_HIGHLIGHT_EN
                hl_file_q   <= hl_file;
                hl_rank_q   <= hl_rank;
`endif
            end
        end
    end

    // Logical index k: file letter 'A'+k, rank digit '1'+k.
    int         idx_i, k_file, k_rank;
    logic [6:0] ch_n;
    logic       on_n;

    always_comb begin
        idx_i  = {28'd0, idx_q};
        k_file = flip_active ? (N_SQ - 1 - idx_i) : idx_i;
        k_rank = flip_active ? idx_i : (N_SQ - 1 - idx_i);
        ch_n   = file_q ? 7'(65 + k_file) : 7'(49 + k_rank);
        on_n   = file_q || rank_q;
    end

`ifdef LABEL_HIGHLIGHT_EN
    logic hl_n;
    assign hl_n = (file_q && (k_file == {28'd0, hl_file_q})) ||
                  (rank_q && (k_rank == {28'd0, hl_rank_q}));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            char_addr  <= '0;
            char_col   <= '0;
            label_on   <= 1'b0;
`ifdef LABEL_HIGHLIGHT_EN
            label_hl   <= 1'b0;
`endif
        end else begin
            hcount_out <= h1;
            vcount_out <= v1;
            label_on   <= on_n;
            char_addr  <= on_n ? {ch_n, line_q} : '0;
            char_col   <= on_n ? col_q : '0;
`ifdef LABEL_HIGHLIGHT_EN
            label_hl   <= on_n && hl_n;
`endif
        end
    end

endmodule

// File: tb/tb_board_label_gen.sv
// Randomized self-checking bench for board_label_gen against a cell-enumeration reference model;
// a second instance covers the 4x4 board with 32-pixel squares.
module tb_board_label_gen;

    localparam int BX = 256, BY = 128, GAP = 8, GW = 8, GH = 16;

    typedef struct packed {
        logic        on;
        logic [10:0] addr;
        logic [2:0]  col;
        logic        hl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        flip_req = 1'b0;
    logic [3:0]  hl_file = '0, hl_rank = '0;
    logic [10:0] hcount_out, vcount_out, char_addr, s_hout, s_vout, s_char_addr;
    logic [2:0]  char_col, s_char_col;
    logic        label_on, s_label_on;
    logic        label_hl, s_label_hl;

    int   vectors = 0, miscompares = 0;
    logic m_flip = 1'b0;
    int   m_hf = 0, m_hr = 0;

    always #5 clk = ~clk;

    board_label_gen dut (
        .clk(clk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in), .flip_req(flip_req),
`ifdef LABEL_HIGHLIGHT_EN
        .hl_file(hl_file), .hl_rank(hl_rank), .label_hl(label_hl),
`endif
        .hcount_out(hcount_out), .vcount_out(vcount_out), .char_addr(char_addr),
        .char_col(char_col), .label_on(label_on)
    );

    board_label_gen #(.N_SQ(4), .SQ_LOG2(5)) dut_small (
        .clk(clk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in), .flip_req(flip_req),
`ifdef LABEL_HIGHLIGHT_EN
        .hl_file(hl_file), .hl_rank(hl_rank), .label_hl(s_label_hl),
`endif
        .hcount_out(s_hout), .vcount_out(s_vout), .char_addr(s_char_addr),
        .char_col(s_char_col), .label_on(s_label_on)
    );

`ifndef LABEL_HIGHLIGHT_EN
    assign label_hl   = 1'b0;
    assign s_label_hl = 1'b0;
`endif

    // Enumerates every label cell of an n x n board and returns what the pixel should show.
    function automatic exp_t model(int n, int sl, int x, int y, logic fl, int hf, int hr);
        exp_t e;
        int s, b, ch, cx, cy, ty, lx;
        e = '0;
        s = 1 << sl;
        b = n * s;
        for (int f = 0; f < n; f++) begin
            for (int t = 0; t < 2; t++) begin
                cx = BX + f * s + (s - GW) / 2;
                ty = (t == 0) ? BY - GAP - GH : BY + b + GAP;
                if (x >= cx && x <= cx + GW - 1 && y >= ty && y <= ty + GH - 1) begin
                    ch     = fl ? 65 + (n - 1 - f) : 65 + f;
                    e.on   = 1'b1;
                    e.addr = 11'(ch * 16 + (y - ty));
                    e.col  = 3'(x - cx);
                    e.hl   = ((ch - 65) == hf);
                end
            end
        end
        for (int r = 0; r < n; r++) begin
            for (int t = 0; t < 2; t++) begin
                cy = BY + r * s + (s - GH) / 2;
                lx = (t == 0) ? BX - GAP - GW : BX + b + GAP;
                if (x >= lx && x <= lx + GW - 1 && y >= cy && y <= cy + GH - 1) begin
                    ch     = fl ? 49 + r : 48 + (n - r);
                    e.on   = 1'b1;
                    e.addr = 11'(ch * 16 + (y - cy));
                    e.col  = 3'(x - lx);
                    e.hl   = ((ch - 49) == hr);
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input int x, input int y);
        hcount_in = 11'(x);
        vcount_in = 11'(y);
        if (x == 0 && y == 0) begin
            m_flip = flip_req;
            m_hf   = int'(hl_file);
            m_hr   = int'(hl_rank);
        end
    endtask

    // Present one pixel, wait for it to reach the outputs, return expected results for both instances.
    task automatic pix(input int x, input int y, output exp_t e, output exp_t es);
        @(negedge clk);
        drive(x, y);
        e  = model(8, 6, x, y, m_flip, m_hf, m_hr);
        es = model(4, 5, x, y, m_flip, m_hf, m_hr);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, es;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        pix(284, 104, e, es);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (label_on !== 1'b0 || char_addr !== 11'h0 || char_col !== 3'd0 ||
            hcount_out !== 11'd0 || vcount_out !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_clear: on=%b addr=%h col=%0d h=%0d v=%0d, required all zero",
                     label_on, char_addr, char_col, hcount_out, vcount_out);
        end
        m_flip = 1'b0; m_hf = 0; m_hr = 0;
        @(negedge clk) rst_n = 1'b1;
        flip_req = 1'b1;
        pix(284, 104, e, es);
        vectors++;
        if (char_addr !== 11'h410 || char_addr !== e.addr) begin
            miscompares++;
            $display("FAIL reset_unflipped: addr=%h required 410", char_addr);
        end
    endtask

    task automatic test_top_file();
        exp_t e, es;
        int xs[3] = '{284, 291, 292};
        int ys[3] = '{104, 119, 104};
        logic [10:0] ka[3] = '{11'h410, 11'h41F, 11'h000};
        logic [2:0]  kc[3] = '{3'd0, 3'd7, 3'd0};
        logic        ko[3] = '{1'b1, 1'b1, 1'b0};
        flip_req = 1'b0;
        pix(0, 0, e, es);
        for (int i = 0; i < 3; i++) begin
            pix(xs[i], ys[i], e, es);
            vectors++;
            if (char_addr !== ka[i] || char_col !== kc[i] || label_on !== ko[i] || char_addr !== e.addr) begin
                miscompares++;
                $display("FAIL top_file(%0d,%0d): addr=%h col=%0d on=%b required addr=%h col=%0d on=%b",
                         xs[i], ys[i], char_addr, char_col, label_on, ka[i], kc[i], ko[i]);
            end
        end
    endtask

    task automatic test_rank_bottom();
        exp_t e, es;
        int xs[4] = '{240, 783, 732, 248};
        int ys[4] = '{152, 167, 663, 152};
        logic [10:0] ka[4] = '{11'h380, 11'h38F, 11'h48F, 11'h000};
        logic [2:0]  kc[4] = '{3'd0, 3'd7, 3'd0, 3'd0};
        logic        ko[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            pix(xs[i], ys[i], e, es);
            vectors++;
            if (char_addr !== ka[i] || char_col !== kc[i] || label_on !== ko[i] || char_col !== e.col) begin
                miscompares++;
                $display("FAIL rank_bottom(%0d,%0d): addr=%h col=%0d on=%b required addr=%h col=%0d on=%b",
                         xs[i], ys[i], char_addr, char_col, label_on, ka[i], kc[i], ko[i]);
            end
        end
    endtask

    task automatic test_flip_sync();
        exp_t e, es;
        pix(500, 300, e, es);
        flip_req = 1'b1;
        pix(284, 648, e, es);
        vectors++;
        if (char_addr !== 11'h410 || char_addr !== e.addr) begin
            miscompares++;
            $display("FAIL flip_midframe: addr=%h required 410", char_addr);
        end
        pix(0, 0, e, es);
        pix(284, 104, e, es);
        vectors++;
        if (char_addr !== 11'h480 || char_addr !== e.addr) begin
            miscompares++;
            $display("FAIL flip_file: addr=%h required 480", char_addr);
        end
        pix(240, 152, e, es);
        vectors++;
        if (char_addr !== 11'h310 || char_addr !== e.addr) begin
            miscompares++;
            $display("FAIL flip_rank: addr=%h required 310", char_addr);
        end
        flip_req = 1'b0;
        pix(0, 0, e, es);
    endtask

    task automatic test_boundaries();
        exp_t e, es;
        int xs[3] = '{0, 240, 1023};
        int ys[3] = '{0, 104, 767};
        for (int i = 0; i < 3; i++) begin
            pix(xs[i], ys[i], e, es);
            vectors++;
            if (label_on !== 1'b0 || char_addr !== 11'h0 || char_col !== 3'd0) begin
                miscompares++;
                $display("FAIL boundary(%0d,%0d): on=%b addr=%h col=%0d required 0",
                         xs[i], ys[i], label_on, char_addr, char_col);
            end
        end
        pix(BX + 12, 104, e, es);
        vectors++;
        if (s_label_on !== 1'b1 || s_char_addr !== 11'h410 || s_char_addr !== es.addr) begin
            miscompares++;
            $display("FAIL small_file_A: on=%b addr=%h required on=1 addr=410", s_label_on, s_char_addr);
        end
        pix(240, 136, e, es);
        vectors++;
        if (s_label_on !== 1'b1 || s_char_addr !== 11'h340) begin
            miscompares++;
            $display("FAIL small_rank_4: on=%b addr=%h required on=1 addr=340", s_label_on, s_char_addr);
        end
    endtask

    task automatic test_random();
        exp_t e, es;
        int x, y;
        for (int i = 0; i < 200; i++) begin
            flip_req = 1'($urandom_range(0, 1));
            hl_file  = 4'($urandom_range(0, 8));
            hl_rank  = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) begin x = 0; y = 0; end
            else begin x = $urandom_range(200, 840); y = $urandom_range(80, 700); end
            pix(x, y, e, es);
            vectors++;
            if (label_on !== e.on || char_addr !== e.addr || char_col !== e.col) begin
                miscompares++;
                $display("FAIL random8(%0d,%0d): on=%b addr=%h col=%0d required on=%b addr=%h col=%0d",
                         x, y, label_on, char_addr, char_col, e.on, e.addr, e.col);
            end
            vectors++;
            if (s_label_on !== es.on || s_char_addr !== es.addr || s_char_col !== es.col) begin
                miscompares++;
                $display("FAIL random4(%0d,%0d): on=%b addr=%h col=%0d required on=%b addr=%h col=%0d",
                         x, y, s_label_on, s_char_addr, s_char_col, es.on, es.addr, es.col);
            end
`ifdef LABEL_HIGHLIGHT_EN
            vectors++;
            if (label_hl !== (e.on & e.hl)) begin
                miscompares++;
                $display("FAIL random_hl(%0d,%0d): hl=%b required %b", x, y, label_hl, e.on & e.hl);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t eq[$];
        int   xq[$], yq[$];
        exp_t e;
        int   x, y;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i < 300) begin
                if ($urandom_range(0, 7) == 0) flip_req = ~flip_req;
                if ($urandom_range(0, 31) == 0) begin x = 0; y = 0; end
                else begin x = $urandom_range(200, 840); y = $urandom_range(80, 700); end
                drive(x, y);
                eq.push_back(model(8, 6, x, y, m_flip, m_hf, m_hr));
                xq.push_back(x);
                yq.push_back(y);
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                e = eq.pop_front();
                x = xq.pop_front();
                y = yq.pop_front();
                vectors++;
                if (label_on !== e.on || char_addr !== e.addr || char_col !== e.col ||
                    hcount_out !== 11'(x) || vcount_out !== 11'(y)) begin
                    miscompares++;
                    $display("FAIL stream(%0d,%0d): on=%b addr=%h col=%0d h=%0d v=%0d required on=%b addr=%h col=%0d",
                             x, y, label_on, char_addr, char_col, hcount_out, vcount_out, e.on, e.addr, e.col);
                end
            end
        end
    endtask

`ifdef LABEL_HIGHLIGHT_EN
    task automatic test_highlight();
        exp_t e, es;
        int xs[3] = '{412, 284, 240};
        int ys[3] = '{104, 104, 600};
        logic kh[3] = '{1'b1, 1'b0, 1'b1};
        flip_req = 1'b0;
        hl_file  = 4'd2;
        hl_rank  = 4'd0;
        pix(0, 0, e, es);
        for (int i = 0; i < 3; i++) begin
            pix(xs[i], ys[i], e, es);
            vectors++;
            if (label_hl !== kh[i] || label_hl !== (e.on & e.hl)) begin
                miscompares++;
                $display("FAIL highlight(%0d,%0d): hl=%b required %b", xs[i], ys[i], label_hl, kh[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_top_file();
        test_rank_bottom();
        test_flip_sync();
        test_boundaries();
`ifdef LABEL_HIGHLIGHT_EN
        test_highlight();
`endif
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
